// File: rtl/ex_branch_resolve.sv
// EX-stage branch resolution: evaluates beq/bne, trains fetch via registered EX_IF_* bus,
// and sequences IF/ID flushes on mispredict. Optional counters under EX_BRANCH_STATS_EN.
module ex_branch_resolve #(
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter logic [31:0] NO_PRED      = 32'h0000_0001
) (
  input  logic        clk,
  input  logic        EX_rst_n,
  input  logic        EX_enable,
  input  logic        ID_EX_branch,
  input  logic        ID_EX_bne,
  input  logic [31:0] ID_EX_pc,
  input  logic [15:0] ID_EX_imm,
  input  logic [31:0] ID_EX_rs_data,
  input  logic [31:0] ID_EX_rt_data,
  input  logic [31:0] ID_EX_branch_target_predict,
  input  logic [1:0]  ID_EX_predictor,
  output logic        EX_IF_branch,
  output logic        EX_IF_zero,
  output logic [31:0] EX_IF_branch_target,
  output logic [31:0] EX_IF_branch_target_predict,
  output logic [31:0] EX_IF_pc,
  output logic        EX_IF_redirect,
  output logic [31:0] EX_IF_redirect_pc,
  output logic        EX_IF_flush,
  output logic        EX_ID_flush
`ifdef EX_BRANCH_STATS_EN
  ,
  output logic [15:0] EX_stat_branches,
  output logic [15:0] EX_stat_mispredicts
`endif
);

  typedef enum logic {IDLE, FLUSH} state_t;

  localparam logic [1:0] CNT_INIT = 2'(FLUSH_CYCLES - 1);

  state_t      state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [31:0] target;
  logic        taken, pt, br_v, mispredict;

  assign target     = ID_EX_pc + {{14{ID_EX_imm[15]}}, ID_EX_imm, 2'b00};
  assign taken      = (ID_EX_rs_data == ID_EX_rt_data) ^ ID_EX_bne;
  assign pt         = ID_EX_predictor[1] && (ID_EX_branch_target_predict != NO_PRED);
  // Branches seen during a flush are wrong-path and must not resolve or train.
  assign br_v       = ID_EX_branch && (state_q == IDLE);
  assign mispredict = br_v && (taken ? (!pt || (ID_EX_branch_target_predict != target)) : pt);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (EX_enable) begin
      case (state_q)
        IDLE: if (mispredict) begin
          state_d = FLUSH;
          cnt_d   = CNT_INIT;
        end
        FLUSH: if (cnt_q == 2'd0) state_d = IDLE;
               else               cnt_d   = cnt_q - 2'd1;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge EX_rst_n) begin
    if (!EX_rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign EX_IF_flush = (state_q == FLUSH);
  assign EX_ID_flush = (state_q == FLUSH);

  always_ff @(posedge clk or negedge EX_rst_n) begin
    if (!EX_rst_n) begin
      EX_IF_branch                <= 1'b0;
      EX_IF_zero                  <= 1'b0;
      EX_IF_branch_target         <= 32'h0;
      EX_IF_branch_target_predict <= NO_PRED;
      EX_IF_pc                    <= 32'h0;
      EX_IF_redirect              <= 1'b0;
      EX_IF_redirect_pc           <= 32'h0;
    end else if (!EX_enable) begin
      // Stall: data holds, but pulses clear so the consumer sees each event once.
      EX_IF_branch   <= 1'b0;
      EX_IF_redirect <= 1'b0;
    end else begin
      EX_IF_branch                <= br_v;
      EX_IF_zero                  <= br_v && taken;
      EX_IF_branch_target         <= target;
      EX_IF_branch_target_predict <= br_v ? ID_EX_branch_target_predict : NO_PRED;
      EX_IF_pc                    <= ID_EX_pc;
      EX_IF_redirect              <= mispredict;
      EX_IF_redirect_pc           <= taken ? target : ID_EX_pc;
    end
  end

`ifdef EX_BRANCH_STATS_EN
  always_ff @(posedge clk or negedge EX_rst_n) begin
    if (!EX_rst_n) begin
      EX_stat_branches    <= 16'h0;
      EX_stat_mispredicts <= 16'h0;
    end else if (EX_enable) begin
      if (br_v && (EX_stat_branches != 16'hFFFF))
        EX_stat_branches <= EX_stat_branches + 16'd1;
      if (mispredict && (EX_stat_mispredicts != 16'hFFFF))
        EX_stat_mispredicts <= EX_stat_mispredicts + 16'd1;
    end
  end
`endif

endmodule

// File: doc/ex_branch_resolve.md
Name: ex_branch_resolve

Overview:
- EX-stage branch resolution unit; the producer end of the EX->IF branch feedback interface consumed by the fetch stage and its predictor.
- Takes the branch carried down ID_EX (pc+4, offset, operands, fetch-time prediction) and evaluates the condition and target.
- Drives the registered EX_IF_* bus that trains the 2-bit predictor and BTB, and detects mispredictions.
- Sequences the fetch/decode flush through a small FSM.

Parameters:
- FLUSH_CYCLES, 2, cycles EX_IF_flush stays asserted per misprediction (1..3).
- NO_PRED, 32'h0000_0001, sentinel in the predicted-target field meaning "no BTB prediction made".

Ports:
- clk  input  1  clock
- EX_rst_n  input  1  asynchronous active-low reset
- EX_enable  input  1  stage advance; 0 = hold all state
- ID_EX_branch  input  1  instruction in EX is a conditional branch
- ID_EX_bne  input  1  0 = beq (taken if equal), 1 = bne
- ID_EX_pc  input  32  pc+4 of the branch
- ID_EX_imm  input  16  signed word offset
- ID_EX_rs_data  input  32  forwarded operand A
- ID_EX_rt_data  input  32  forwarded operand B
- ID_EX_branch_target_predict  input  32  target predicted at fetch, or NO_PRED
- ID_EX_predictor  input  2  counter value at fetch
- EX_IF_branch  output  1  registered: resolved branch valid
- EX_IF_zero  output  1  registered: branch taken
- EX_IF_branch_target  output  32  registered computed target
- EX_IF_branch_target_predict  output  32  registered copy of the prediction
- EX_IF_pc  output  32  registered pc+4 of the branch
- EX_IF_redirect  output  1  registered: misprediction, fetch must restart
- EX_IF_redirect_pc  output  32  registered restart address
- EX_IF_flush  output  1  flush IF/ID register
- EX_ID_flush  output  1  flush ID/EX register

Behaviour:
- Reset (async, EX_rst_n=0): all EX_IF_* outputs 0, except EX_IF_branch_target_predict = NO_PRED. EX_IF_flush = 0, EX_ID_flush = 0. FSM = IDLE, flush counter = 0.
- Target: ID_EX_pc + ({{14{imm[15]}}, imm, 2'b00}), modulo 2^32. Wrap-around is allowed.
- Condition: eq = (rs_data == rt_data); taken = eq XOR ID_EX_bne.
- Predicted taken (pt) = ID_EX_predictor[1] AND (ID_EX_branch_target_predict != NO_PRED).
- Mispredict, evaluated only when ID_EX_branch = 1 and FSM = IDLE:
  - taken and !pt: redirect to target.
  - taken and pt and predicted target != target: redirect to target.
  - !taken and pt: redirect to ID_EX_pc.
  - !taken and !pt: correct, no redirect.
- Latency: all EX_IF_* outputs are registered and valid one cycle after the branch is in EX.
- EX_IF_branch and EX_IF_redirect are single-cycle pulses.
- Non-branch cycles: EX_IF_branch = 0, EX_IF_zero = 0, EX_IF_redirect = 0, and the predict field is reloaded with NO_PRED.
- FSM states:
  - IDLE: on a mispredict, go to FLUSH with counter = FLUSH_CYCLES-1.
  - FLUSH: EX_IF_flush = 1 and EX_ID_flush = 1 (registered, starting in the same cycle the redirect pulse appears). Counter decrements each cycle; return to IDLE after the cycle in which counter = 0.
- While in FLUSH:
  - ID_EX_branch is ignored, since the instruction is wrong-path.
  - EX_IF_branch stays 0 so the predictor is not trained by wrong-path branches.
- EX_enable = 0:
  - all registers and the FSM hold;
  - pulse outputs are forced to 0 so nothing is double-counted;
  - a flush already in progress is extended, not lost.
- Reset mid-flush returns immediately to IDLE with the flushes deasserted.
- A branch in EX with ID_EX_branch = 0 (bubble) never trains the predictor or redirects.

Optional Feature:
- Macro: EX_BRANCH_STATS_EN.
- When defined:
  - Adds outputs EX_stat_branches[15:0] and EX_stat_mispredicts[15:0].
  - Counts resolved branches and redirects, i.e. the cycles EX_IF_branch and EX_IF_redirect are 1.
  - Counters saturate at 16'hFFFF and reset to 0.
- When undefined: ports and logic are absent; all other behaviour is identical.

Test Plan:
- beq, rs = rt = 5, pc = 0x40, imm = 3, pred = 0x4C, predictor = 2'b11 -> next cycle EX_IF_branch = 1, zero = 1, target = 0x4C, redirect = 0, no flush.
- beq, rs = 5, rt = 6, pc = 0x40, pred = 0x4C, predictor = 2'b10 -> redirect = 1, redirect_pc = 0x40, EX_IF_flush high for exactly 2 cycles.
- bne, rs = 1, rt = 2, pc = 0x100, imm = 16'hFFFC, pred = NO_PRED -> zero = 1, target = 0xF0, redirect = 1, redirect_pc = 0xF0.
- Mispredict immediately followed by a wrong-path taken branch -> second branch ignored: EX_IF_branch = 0, no second redirect.
- pc = 0xFFFF_FFFC, imm = 2 -> target = 0x0000_0004 (wrap); EX_rst_n asserted mid-flush -> flushes drop to 0 asynchronously, predict field = 0x1.
- With EX_BRANCH_STATS_EN: 3 branches of which 1 mispredicted -> stat_branches = 3, stat_mispredicts = 1; preload 0xFFFF and add one more branch -> stays 0xFFFF.
